// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit and the downstream reduce stage:
// width_src encodings and the LSU state machine encoding.
package load_store_unit_pkg;

  // width_src_i encodings; the reduce stage decodes sign extension from these too.
  localparam logic [2:0] WS_WORD   = 3'b000;
  localparam logic [2:0] WS_HALF_S = 3'b010;
  localparam logic [2:0] WS_HALF_U = 3'b110;
  localparam logic [2:0] WS_BYTE_S = 3'b001;
  localparam logic [2:0] WS_BYTE_U = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_e;

  function automatic logic is_half(input logic [2:0] ws);
    return (ws == WS_HALF_S) || (ws == WS_HALF_U);
  endfunction

  function automatic logic is_byte(input logic [2:0] ws);
    return (ws == WS_BYTE_S) || (ws == WS_BYTE_U);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication and the legality
// check for a new request, plus shift/mask of a returning load word.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  width_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        illegal_o,
  input  logic [2:0]  ld_width_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shifted;

  always_comb begin
    be_o      = 4'b0000;
    wdata_o   = wdata_i;
    illegal_o = 1'b0;
    if (width_i == WS_WORD) begin
      be_o      = 4'b1111;
      illegal_o = (addr_lo_i != 2'b00);
    end else if (is_half(width_i)) begin
      be_o      = 4'b0011 << addr_lo_i;
      wdata_o   = {2{wdata_i[15:0]}};
      illegal_o = addr_lo_i[0];
    end else if (is_byte(width_i)) begin
      be_o      = 4'b0001 << addr_lo_i;
      wdata_o   = {4{wdata_i[7:0]}};
    end else begin
      illegal_o = 1'b1;
    end
  end

  // Zero fill only; sign extension happens in the reduce stage.
  always_comb begin
    ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};
    if (is_byte(ld_width_i)) begin
      ld_data_o = {24'h000000, ld_shifted[7:0]};
    end else if (is_half(ld_width_i)) begin
      ld_data_o = {16'h0000, ld_shifted[15:0]};
    end else begin
      ld_data_o = ld_shifted;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one execute-stage memory request at a time, issues it
// on the dmem bus and returns right-aligned, zero-filled load data.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  width_src_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        access_fault_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  ld_width_q, ld_width_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        fault_q, fault_d;

  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        req_illegal;
  logic [31:0] ld_data;
  logic        stall;

  lsu_align u_align (
    .width_i    (width_src_i),
    .addr_lo_i  (addr_i[1:0]),
    .wdata_i    (wdata_i),
    .be_o       (req_be),
    .wdata_o    (req_wdata),
    .illegal_o  (req_illegal),
    .ld_width_i (ld_width_q),
    .ld_off_i   (ld_off_q),
    .ld_rdata_i (dmem_rdata_i),
    .ld_data_o  (ld_data)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    we_d          = we_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    ld_width_d    = ld_width_q;
    ld_off_d      = ld_off_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    fault_d       = 1'b0;
    stall         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (req_illegal) begin
            fault_d = 1'b1;
          end else begin
            stall      = 1'b1;
            state_d    = ST_REQ;
            addr_d     = {addr_i[31:2], 2'b00};
            we_d       = req_we_i;
            be_d       = req_be;
            wdata_d    = req_wdata;
            ld_width_d = width_src_i;
            ld_off_d   = addr_i[1:0];
          end
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        if (dmem_gnt_i) begin
          // A granted store retires now; a load still owes its data.
          if (we_q) begin
            stall   = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (dmem_rvalid_i) begin
          stall         = 1'b0;
          rdata_d       = ld_data;
          rdata_valid_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= ST_IDLE;
      addr_q        <= 32'h0;
      we_q          <= 1'b0;
      be_q          <= 4'h0;
      wdata_q       <= 32'h0;
      ld_width_q    <= WS_WORD;
      ld_off_q      <= 2'b00;
      rdata_q       <= 32'h0;
      rdata_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
      ld_width_q    <= ld_width_d;
      ld_off_q      <= ld_off_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      fault_q       <= fault_d;
    end
  end

  assign stall_o        = stall;
  assign rdata_o        = rdata_q;
  assign rdata_valid_o  = rdata_valid_q;
  assign access_fault_o = fault_q;
  assign dmem_req_o     = (state_q == ST_REQ);
  assign dmem_we_o      = we_q;
  assign dmem_addr_o    = addr_q;
  assign dmem_be_o      = be_q;
  assign dmem_wdata_o   = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit: stimulus pushes expected bus
// transactions, load results and faults; a monitor pops them as the DUT emits them.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        req_valid_i;
  logic        req_we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [2:0]  width_src_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        access_fault_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  load_store_unit dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .req_valid_i    (req_valid_i),
    .req_we_i       (req_we_i),
    .addr_i         (addr_i),
    .wdata_i        (wdata_i),
    .width_src_i    (width_src_i),
    .stall_o        (stall_o),
    .rdata_o        (rdata_o),
    .rdata_valid_o  (rdata_valid_o),
    .access_fault_o (access_fault_o),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_be_o      (dmem_be_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_gnt_i     (dmem_gnt_i),
    .dmem_rvalid_i  (dmem_rvalid_i),
    .dmem_rdata_i   (dmem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_txn_t;

  bus_txn_t    bus_q[$];
  logic [31:0] rd_q[$];
  int          fault_exp = 0;
  int          checks = 0;
  int          errors = 0;

  // Memory responder controls.
  int          gnt_dly = 0;
  int          rv_dly = 1;
  bit          gnt_always = 1'b0;
  bit          rv_en = 1'b1;
  logic [31:0] mem_word = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present a request and hold it until the DUT stops stalling; exp_stall is the
  // hand-counted number of cycles stall_o should be high while it is presented.
  task automatic issue(input string nm, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] w, input int exp_stall);
    int  n;
    bit  done;
    req_valid_i = 1'b1;
    req_we_i    = we;
    addr_i      = a;
    wdata_i     = d;
    width_src_i = w;
    n    = 0;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      #1;
      if (!stall_o) done = 1'b1;
      else n++;
      @(negedge clk_i);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: stall_o still high after 60 cycles, required release", nm);
    end
    chk({nm, " stall cycles"}, n, exp_stall);
  endtask

  task automatic go_idle();
    req_valid_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic exp_bus(input logic we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] d);
    bus_txn_t t;
    t.we = we; t.addr = a; t.be = be; t.wdata = d;
    bus_q.push_back(t);
  endtask

  // Memory model: grants after gnt_dly cycles in REQ, returns load data rv_dly cycles later.
  initial begin
    bit is_load;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'h0;
    forever begin
      @(negedge clk_i);
      if (dmem_req_o) begin
        repeat (gnt_dly) @(negedge clk_i);
        dmem_gnt_i = 1'b1;
        is_load = !dmem_we_o;
        @(negedge clk_i);
        if (!gnt_always) dmem_gnt_i = 1'b0;
        if (is_load && rv_en) begin
          repeat (rv_dly - 1) @(negedge clk_i);
          dmem_rdata_i  = mem_word;
          dmem_rvalid_i = 1'b1;
          @(negedge clk_i);
          dmem_rvalid_i = 1'b0;
        end
      end
    end
  end

  // Monitor: every handshake, load result and fault must match a queued expectation.
  initial begin
    bus_txn_t e;
    logic [31:0] r;
    forever begin
      @(negedge clk_i);
      #2;
      if (dmem_req_o && dmem_gnt_i) begin
        $display("dmem txn we=%0d addr=%h be=%b wdata=%h", dmem_we_o, dmem_addr_o,
                 dmem_be_o, dmem_wdata_o);
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected dmem txn: addr %h, required none", dmem_addr_o);
        end else begin
          e = bus_q.pop_front();
          chk("dmem_we", {31'h0, dmem_we_o}, {31'h0, e.we});
          chk("dmem_addr", dmem_addr_o, e.addr);
          chk("dmem_be", {28'h0, dmem_be_o}, {28'h0, e.be});
          chk("dmem_wdata", dmem_wdata_o, e.wdata);
        end
      end
      if (rdata_valid_o) begin
        $display("load result rdata=%h", rdata_o);
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected rdata_valid: rdata %h, required none", rdata_o);
        end else begin
          r = rd_q.pop_front();
          chk("rdata", rdata_o, r);
        end
      end
      if (access_fault_o) begin
        $display("access fault");
        checks++;
        if (fault_exp == 0) begin
          errors++;
          $display("FAIL unexpected access_fault: got 1 required 0");
        end else begin
          fault_exp--;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_i      = 1'b0;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    addr_i      = 32'h0;
    wdata_i     = 32'h0;
    width_src_i = 3'b000;
    repeat (2) @(negedge clk_i);
    #1;
    chk("reset stall_o", {31'h0, stall_o}, 32'h0);
    chk("reset dmem_req_o", {31'h0, dmem_req_o}, 32'h0);
    chk("reset dmem_be_o", {28'h0, dmem_be_o}, 32'h0);
    chk("reset dmem_addr_o", dmem_addr_o, 32'h0);
    chk("reset dmem_wdata_o", dmem_wdata_o, 32'h0);
    chk("reset rdata_o", rdata_o, 32'h0);
    chk("reset rdata_valid_o", {31'h0, rdata_valid_o}, 32'h0);
    chk("reset access_fault_o", {31'h0, access_fault_o}, 32'h0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);

    // Word load, grant after 2 cycles, data 3 cycles after grant.
    gnt_dly = 2; rv_dly = 3; mem_word = 32'hDEADBEEF;
    exp_bus(1'b0, 32'h100, 4'b1111, 32'h0);
    rd_q.push_back(32'hDEADBEEF);
    issue("word load 0x100", 1'b0, 32'h100, 32'h0, 3'b000, 6);
    go_idle();

    gnt_dly = 0; rv_dly = 1; mem_word = 32'h80FF1234;
    exp_bus(1'b0, 32'h100, 4'b1000, 32'h0);
    rd_q.push_back(32'h00000080);
    issue("byte load 0x103", 1'b0, 32'h103, 32'h0, 3'b001, 2);
    go_idle();

    exp_bus(1'b1, 32'h0A0, 4'b1100, 32'hABCDABCD);
    issue("half store 0x0A2", 1'b1, 32'h0A2, 32'h0000ABCD, 3'b010, 1);
    go_idle();

    fault_exp++;
    issue("word load 0x101", 1'b0, 32'h101, 32'h0, 3'b000, 0);
    go_idle();
    fault_exp++;
    issue("width 011", 1'b0, 32'h100, 32'h0, 3'b011, 0);
    go_idle();
    fault_exp++;
    issue("half load 0x203", 1'b0, 32'h203, 32'h0, 3'b010, 0);
    go_idle();

    mem_word = 32'h12345678;
    exp_bus(1'b0, 32'h200, 4'b1100, 32'h0);
    rd_q.push_back(32'h00001234);
    issue("half u load 0x202", 1'b0, 32'h202, 32'h0, 3'b110, 2);
    go_idle();

    mem_word = 32'hAABBCCDD;
    exp_bus(1'b0, 32'h200, 4'b0010, 32'h0);
    rd_q.push_back(32'h000000CC);
    issue("byte u load 0x201", 1'b0, 32'h201, 32'h0, 3'b101, 2);
    go_idle();

    exp_bus(1'b1, 32'h300, 4'b0100, 32'h77777777);
    issue("byte store 0x302", 1'b1, 32'h302, 32'h12345677, 3'b001, 1);
    go_idle();

    exp_bus(1'b1, 32'h404, 4'b1111, 32'hCAFEF00D);
    issue("word store 0x404", 1'b1, 32'h404, 32'hCAFEF00D, 3'b000, 1);
    go_idle();

    gnt_dly = 1; rv_dly = 2; mem_word = 32'hFEDC0000;
    exp_bus(1'b0, 32'h104, 4'b1100, 32'h0);
    rd_q.push_back(32'h0000FEDC);
    issue("half load 0x106", 1'b0, 32'h106, 32'h0, 3'b010, 4);
    go_idle();

    // Back-to-back store then load with grant held high.
    gnt_dly = 0; rv_dly = 1; gnt_always = 1'b1; mem_word = 32'h55667788;
    exp_bus(1'b1, 32'h500, 4'b1111, 32'h11223344);
    exp_bus(1'b0, 32'h500, 4'b0010, 32'h0);
    rd_q.push_back(32'h00000077);
    issue("b2b store 0x500", 1'b1, 32'h500, 32'h11223344, 3'b000, 1);
    issue("b2b load 0x501", 1'b0, 32'h501, 32'h0, 3'b001, 2);
    go_idle();
    gnt_always = 1'b0;
    dmem_gnt_i = 1'b0;
    repeat (3) @(negedge clk_i);

    // Reset while waiting for load data; the late rvalid must be ignored.
    rv_en = 1'b0;
    exp_bus(1'b0, 32'h600, 4'b1111, 32'h0);
    req_valid_i = 1'b1; req_we_i = 1'b0; addr_i = 32'h600; wdata_i = 32'h0;
    width_src_i = 3'b000;
    @(negedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    rstn_i = 1'b0;
    #1;
    chk("async reset dmem_addr_o", dmem_addr_o, 32'h0);
    chk("async reset dmem_be_o", {28'h0, dmem_be_o}, 32'h0);
    chk("async reset rdata_o", rdata_o, 32'h0);
    chk("async reset stall_o", {31'h0, stall_o}, 32'h0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    dmem_rdata_i  = 32'h99999999;
    dmem_rvalid_i = 1'b1;
    #1;
    chk("late rvalid stall_o", {31'h0, stall_o}, 32'h0);
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    #1;
    chk("late rvalid rdata_valid_o", {31'h0, rdata_valid_o}, 32'h0);
    chk("late rvalid rdata_o", rdata_o, 32'h0);
    chk("late rvalid dmem_req_o", {31'h0, dmem_req_o}, 32'h0);
    rv_en = 1'b1;
    repeat (4) @(negedge clk_i);

    chk("pending dmem txns", bus_q.size(), 32'h0);
    chk("pending load results", rd_q.size(), 32'h0);
    chk("pending faults", fault_exp, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
